// File: rtl/bin2bcd_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// One adjust_shift step per clock, 8 steps per conversion, valid/ready on both sides.
module adjust_shift (
  input  logic [19:0] din,
  output logic [19:0] dout
);
  logic [19:0] adj;

  always_comb begin
    adj = din;
    if (din[19:16] > 4'd4) adj[19:16] = din[19:16] + 4'd3;
    if (din[15:12] > 4'd4) adj[15:12] = din[15:12] + 4'd3;
    if (din[11:8]  > 4'd4) adj[11:8]  = din[11:8]  + 4'd3;
    dout = {adj[18:0], 1'b0};
  end
endmodule

module bin2bcd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  idata,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] odata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [19:0] work;
  logic [19:0] work_next;
  logic [2:0]  cnt;

  adjust_shift u_step (
    .din  (work),
    .dout (work_next)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= 20'd0;
      cnt       <= 3'd0;
      odata     <= 12'h000;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= {12'd0, idata};
            cnt   <= 3'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt + 3'd1;
          // eighth step: the BCD field of the shifted value is the result
          if (cnt == 3'd7) begin
            odata     <= work_next[19:8];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Self-checking bench for bin2bcd_ctrl.
// Random and swept values checked against a decimal-digit reference model.
module tb_bin2bcd_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  idata;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] odata;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .idata     (idata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .odata     (odata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for in_ready, present v for one accept edge, count edges to out_valid
  task automatic run_conv(input logic [7:0] v,
                          output logic [11:0] res,
                          output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      step();
      w++;
    end
    idata    = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    res = odata;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; idata = 8'h00;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({odata, out_valid, in_ready, busy} !== {12'h000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: odata=%h ov=%b ir=%b busy=%b, want 000 0 1 0",
               odata, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_zero();
    logic [11:0] r; int lat;
    out_ready = 1'b0;
    run_conv(8'd0, r, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL zero_latency: got %0d edges after accept, want 8", lat);
    end
    checks++;
    if (r !== 12'h000 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: odata=%h busy=%b ir=%b, want 000 1 0",
               r, busy, in_ready);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_max();
    logic [11:0] r; int lat;
    out_ready = 1'b1;
    run_conv(8'd255, r, lat);
    checks++;
    if (r !== 12'h255 || lat !== 8) begin
      errors++;
      $display("FAIL max: odata=%h lat=%0d, want 255 lat 8", r, lat);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || odata !== 12'h255) begin
      errors++;
      $display("FAIL max_release: ov=%b ir=%b odata=%h, want 0 1 255",
               out_valid, in_ready, odata);
    end
  endtask

  task automatic test_sweep();
    logic [11:0] r; int lat; int v;
    out_ready = 1'b1;
    for (int i = 0; i < 256 + 64; i++) begin
      v = (i < 256) ? i : int'($urandom_range(255, 0));
      run_conv(8'(v), r, lat);
      checks++;
      if (r !== ref_bcd(v) || lat !== 8) begin
        errors++;
        $display("FAIL sweep v=%0d: odata=%h lat=%0d, want %h lat 8",
                 v, r, lat, ref_bcd(v));
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [11:0] r; int lat;
    out_ready = 1'b0;
    run_conv(8'd173, r, lat);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({odata, out_valid, busy, in_ready} !== {12'h173, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL backpressure cyc%0d: odata=%h ov=%b busy=%b ir=%b, want 173 1 1 0",
                 k, odata, out_valid, busy, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: ov=%b ir=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_busy_input();
    int lat;
    out_ready = 1'b1;
    idata = 8'd42; in_valid = 1'b1;
    step();
    step();
    idata = 8'd200;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (odata !== 12'h042 || lat !== 8) begin
      errors++;
      $display("FAIL busy_first: odata=%h lat=%0d, want 042 lat 8", odata, lat);
    end
    step();
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (odata !== 12'h200 || lat !== 8) begin
      errors++;
      $display("FAIL busy_second: odata=%h lat=%0d, want 200 lat 8", odata, lat);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [11:0] r; int lat;
    out_ready = 1'b0;
    idata = 8'd128; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({odata, out_valid, in_ready, busy} !== {12'h000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: odata=%h ov=%b ir=%b busy=%b, want 000 0 1 0",
               odata, out_valid, in_ready, busy);
    end
    repeat (10) step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: ov=%b busy=%b, want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    run_conv(8'd128, r, lat);
    checks++;
    if (r !== 12'h128 || lat !== 8) begin
      errors++;
      $display("FAIL reset_mid_after: odata=%h lat=%0d, want 128 lat 8", r, lat);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_sweep();
    test_backpressure();
    test_busy_input();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
